// File: rtl/pipelined_addsub_pkg.sv
// pipelined_addsub_pkg: shared width/depth defaults and add/sub mode encoding
package pipelined_addsub_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational SW-bit ripple-carry slice
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] x,
  input  logic [SW-1:0] y,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout
);
  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, cin};
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep sliced carry-chain adder/subtractor with valid/ready flow control
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int SW = WIDTH / STAGES;
  logic             v    [STAGES];
  logic             c    [STAGES];
  logic             ov   [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             adv;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = c[STAGES-1];
  assign overflow  = ov[STAGES-1];
  assign zero      = out_valid && (sum == '0);
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0] xa, xb, xs;
    logic             xc, xv, co;
    logic [SW-1:0]    ss;
    if (k == 0) begin : g_head
      assign xa = a;
      assign xb = (sub == SUB) ? ~b : b;
      assign xc = (sub == SUB);
      assign xs = '0;
      assign xv = in_valid;
    end else begin : g_tail
      assign xa = a_q[k-1];
      assign xb = b_q[k-1];
      assign xc = c[k-1];
      assign xs = s_q[k-1];
      assign xv = v[k-1];
    end
    adder_slice #(.SW(SW)) u_slice (
      .x   (xa[k*SW +: SW]),
      .y   (xb[k*SW +: SW]),
      .cin (xc),
      .s   (ss),
      .cout(co)
    );
    // stage register: on advance take the predecessor's operands, partial sum and carry; hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v[k]   <= 1'b0;
        c[k]   <= 1'b0;
        ov[k]  <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end else if (adv) begin
        v[k]              <= xv;
        c[k]              <= co;
        ov[k]             <= (xa[WIDTH-1] == xb[WIDTH-1]) && (ss[SW-1] != xa[WIDTH-1]);
        a_q[k]            <= xa;
        b_q[k]            <= xb;
        s_q[k]            <= xs;
        s_q[k][k*SW +: SW] <= ss;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: table, random, backpressure, reset and parameter-sweep checks
module tb_pipelined_addsub;
  typedef struct {logic [7:0] sum; logic c; logic v; logic z; int cyc;} exp_t;
  typedef struct {logic [7:0] a; logic [7:0] b; logic sub; logic [7:0] es; logic ec; logic ev; logic ez;} vec_t;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, sub = 0, out_ready = 1;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid, carry_out, overflow, zero;
  logic [7:0] sum;
  logic w_valid = 0, w_sub = 0, w_rdy = 1;
  logic [31:0] w_a = 0, w_b = 0;
  logic w_ir [3], w_ov [3], w_c [3], w_ovf [3], w_z [3];
  logic [31:0] w_sum [3];
  int checks = 0, errors = 0, cyc = 0, stalls = 0, lat [3];
  bit chk_lat = 0, prev_stall = 0;
  logic [11:0] pv;
  exp_t pend [$];
  exp_t sb [$];
  exp_t me;
  always #5 clk = ~clk;
  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int S = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    pipelined_addsub #(.WIDTH(32), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ir[g]), .a(w_a), .b(w_b), .sub(w_sub),
      .out_valid(w_ov[g]), .out_ready(w_rdy), .sum(w_sum[g]), .carry_out(w_c[g]),
      .overflow(w_ovf[g]), .zero(w_z[g])
    );
  end
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t e;
    int ua, ub, sa, sb2, r, sr;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb2 = int'($signed(y));
    r = s ? ua - ub : ua + ub;
    sr = s ? sa - sb2 : sa + sb2;
    e.sum = r[7:0];
    e.c = s ? (ua >= ub) : (r > 255);
    e.v = (sr > 127) || (sr < -128);
    e.z = (e.sum == 0);
    e.cyc = 0;
    return e;
  endfunction
  // scoreboard: record accepted inputs, compare drained outputs in order, watch stalls
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      cyc++;
      if (prev_stall) check("stall_stable", {out_valid, sum, carry_out, overflow, zero, 1'b0}, {pv, 1'b0});
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        stalls++;
      end
      prev_stall = out_valid && !out_ready;
      pv = {out_valid, sum, carry_out, overflow, zero};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", out_valid, 0);
        else begin
          me = sb.pop_front();
          check("sum", sum, me.sum);
          check("carry", carry_out, me.c);
          check("overflow", overflow, me.v);
          check("zero", zero, me.z);
          if (chk_lat) check("latency", cyc - me.cyc, 2);
        end
      end
      if (in_valid && in_ready && pend.size() > 0) begin
        me = pend.pop_front();
        me.cyc = cyc;
        sb.push_back(me);
      end
    end
  end
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s, input exp_t e);
    int n = 0;
    bit acc = 0;
    a = x;
    b = y;
    sub = s;
    in_valid = 1;
    pend.push_back(e);
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
      void'(pend.pop_back());
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 0;
    while ((sb.size() + pend.size()) > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", sb.size() + pend.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    vec_t tbl [7];
    exp_t e;
    logic [7:0] x, y;
    logic s;
    tbl[0] = '{8'd23, 8'd12, 1'b0, 8'd35, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'd35, 8'd71, 1'b0, 8'd106, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'd35, 8'd71, 1'b1, 8'd220, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'd5, 8'd5, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'd128, 8'd1, 1'b1, 8'd127, 1'b1, 1'b1, 1'b0};
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fields", {sum, carry_out, overflow, zero}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1 chk_lat = 1;
    for (int i = 0; i < 7; i++) begin
      e = '{tbl[i].es, tbl[i].ec, tbl[i].ev, tbl[i].ez, 0};
      send(tbl[i].a, tbl[i].b, tbl[i].sub, e);
    end
    drain();
    chk_lat = 0;
    fork
      for (int i = 0; i < 8; i++) begin
        x = 8'($urandom);
        y = 8'($urandom);
        s = 1'($urandom);
        send(x, y, s, model(x, y, s));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("stall_seen", stalls >= 3, 1);
    fork
      for (int i = 0; i < 60; i++) begin
        x = 8'($urandom);
        y = 8'($urandom);
        s = 1'($urandom);
        send(x, y, s, model(x, y, s));
        if ($urandom_range(3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      for (int i = 0; i < 150; i++) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(2) != 0);
      end
    join
    out_ready = 1;
    drain();
    send(8'd10, 8'd20, 1'b0, model(8'd10, 8'd20, 1'b0));
    send(8'd30, 8'd40, 1'b0, model(8'd30, 8'd40, 1'b0));
    #2 rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    sb.delete();
    pend.delete();
    @(posedge clk);
    #1 rst_n = 1;
    check("rel_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("sw%0d_in_ready", g), w_ir[g], 1);
      lat[g] = 0;
    end
    w_a = 32'hFFFF_FFFF;
    w_b = 32'd1;
    w_sub = 0;
    w_valid = 1;
    @(posedge clk);
    #1 w_valid = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (w_ov[g] && lat[g] == 0) begin
          lat[g] = i;
          check($sformatf("sw%0d_sum", g), w_sum[g], 0);
          check($sformatf("sw%0d_carry", g), w_c[g], 1);
          check($sformatf("sw%0d_zero", g), w_z[g], 1);
          check($sformatf("sw%0d_ovf", g), w_ovf[g], 0);
        end
      end
    end
    check("sw0_latency", lat[0], 1);
    check("sw1_latency", lat[1], 4);
    check("sw2_latency", lat[2], 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
